// File: rtl/waveform_gen_pkg.sv
// Shared types for waveform_gen and its downstream monitors.
package waveform_gen_pkg;

    localparam int unsigned LUT_WIDTH = 8;
    localparam int unsigned AVG_DEPTH = 4;

    typedef enum logic [1:0] {
        WAVE_SINE     = 2'd0,
        WAVE_TRIANGLE = 2'd1,
        WAVE_SAW      = 2'd2,
        WAVE_SQUARE   = 2'd3
    } wave_sel_t;

    typedef enum logic [1:0] {
        DIR_UNKNOWN = 2'd0,
        DIR_RISING  = 2'd1,
        DIR_FALLING = 2'd2
    } dir_state_t;

endpackage

// File: rtl/wave_period_meter_extrema.sv
// wave_extrema_tracker: running min/max of the sample stream with load/update/hold.
module wave_extrema_tracker
    import waveform_gen_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load_i,
    input  logic                        update_i,
    input  logic signed [LUT_WIDTH-1:0] sample_i,
    output logic signed [LUT_WIDTH-1:0] max_o,
    output logic signed [LUT_WIDTH-1:0] min_o
);

    logic signed [LUT_WIDTH-1:0] max_q, max_d;
    logic signed [LUT_WIDTH-1:0] min_q, min_d;

    // Load restarts both trackers on the current sample; update widens them.
    always_comb begin
        max_d = max_q;
        min_d = min_q;
        if (load_i) begin
            max_d = sample_i;
            min_d = sample_i;
        end else if (update_i) begin
            if (sample_i > max_q) max_d = sample_i;
            if (sample_i < min_q) min_d = sample_i;
        end
    end

    // Tracker registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q <= '0;
            min_q <= '0;
        end else begin
            max_q <= max_d;
            min_q <= min_d;
        end
    end

    assign max_o = max_q;
    assign min_o = min_q;

endmodule

// File: rtl/wave_period_meter.sv
// wave_period_meter: peak-to-peak period and per-period min/max of a sample stream.
// Optional feature: define WAVE_PERIOD_AVG_EN to add avg_period_o (mean of last 4 periods).
module wave_period_meter
    import waveform_gen_pkg::*;
#(
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned SETTLE_PERIODS = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic signed [LUT_WIDTH-1:0] wave_i,
    input  wave_sel_t                   wave_sel_i,
    input  logic                        halt_i,
    output logic        [CNT_WIDTH-1:0] period_o,
    output logic                        period_valid_o,
    output logic signed [LUT_WIDTH-1:0] max_o,
    output logic signed [LUT_WIDTH-1:0] min_o,
    output logic                        timeout_o
`ifdef WAVE_PERIOD_AVG_EN
    ,
    output logic        [CNT_WIDTH-1:0] avg_period_o
`endif
);

    localparam int unsigned SET_WIDTH = (SETTLE_PERIODS > 0) ? $clog2(SETTLE_PERIODS + 1) : 1;
    localparam logic [SET_WIDTH-1:0] SETTLE_INIT = SET_WIDTH'(SETTLE_PERIODS);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;

    logic signed [LUT_WIDTH-1:0] prev_q, prev_d;
    dir_state_t                  dir_q, dir_d;
    logic        [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                        armed_q, armed_d;
    logic        [SET_WIDTH-1:0] settle_q, settle_d;
    wave_sel_t                   sel_q;
    logic                        halt_q;
    logic        [CNT_WIDTH-1:0] period_q, period_d;
    logic                        valid_q, valid_d;
    logic signed [LUT_WIDTH-1:0] max_q, max_d;
    logic signed [LUT_WIDTH-1:0] min_q, min_d;
    logic                        timeout_q, timeout_d;

    logic                        run_c;
    logic                        rearm_c;
    logic                        rise_c;
    logic                        fall_c;
    logic                        peak_c;
    logic signed [LUT_WIDTH-1:0] trk_max;
    logic signed [LUT_WIDTH-1:0] trk_min;
    logic signed [LUT_WIDTH-1:0] max_incl_c;
    logic signed [LUT_WIDTH-1:0] min_incl_c;

    // Event decode; a re-arm suppresses a coincident peak entirely.
    always_comb begin
        run_c      = !halt_i;
        rearm_c    = (wave_sel_i != sel_q) || (halt_i && !halt_q);
        rise_c     = run_c && (wave_i > prev_q);
        fall_c     = run_c && (wave_i < prev_q);
        peak_c     = fall_c && (dir_q == DIR_RISING) && !rearm_c;
        max_incl_c = (wave_i > trk_max) ? wave_i : trk_max;
        min_incl_c = (wave_i < trk_min) ? wave_i : trk_min;
    end

    wave_extrema_tracker u_extrema (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (peak_c),
        .update_i (run_c),
        .sample_i (wave_i),
        .max_o    (trk_max),
        .min_o    (trk_min)
    );

    // Direction FSM, period counter, arming/settle and output next-state.
    always_comb begin
        prev_d    = prev_q;
        dir_d     = dir_q;
        cnt_d     = cnt_q;
        armed_d   = armed_q;
        settle_d  = settle_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        max_d     = max_q;
        min_d     = min_q;
        timeout_d = timeout_q;

        if (run_c) begin
            prev_d = wave_i;
            if (rise_c) begin
                dir_d = DIR_RISING;
            end else if (fall_c) begin
                dir_d = DIR_FALLING;
            end

            if (peak_c) begin
                cnt_d = '0;
                if (!armed_q) begin
                    armed_d = 1'b1;
                end else if (settle_q != '0) begin
                    settle_d = settle_q - SET_WIDTH'(1);
                end else begin
                    period_d  = cnt_q + CNT_WIDTH'(1);
                    max_d     = max_incl_c;
                    min_d     = min_incl_c;
                    valid_d   = 1'b1;
                    timeout_d = 1'b0;
                end
            end else begin
                cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_WIDTH'(1);
                if (cnt_d == CNT_MAX) begin
                    timeout_d = 1'b1;
                    armed_d   = 1'b0;
                    settle_d  = SETTLE_INIT;
                end
            end
        end

        if (rearm_c) begin
            armed_d  = 1'b0;
            settle_d = SETTLE_INIT;
            dir_d    = DIR_UNKNOWN;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q    <= '0;
            dir_q     <= DIR_UNKNOWN;
            cnt_q     <= '0;
            armed_q   <= 1'b0;
            settle_q  <= SETTLE_INIT;
            sel_q     <= wave_sel_t'(2'd0);
            halt_q    <= 1'b0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            max_q     <= '0;
            min_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
            settle_q  <= settle_d;
            sel_q     <= wave_sel_i;
            halt_q    <= halt_i;
            period_q  <= period_d;
            valid_q   <= valid_d;
            max_q     <= max_d;
            min_q     <= min_d;
            timeout_q <= timeout_d;
        end
    end

    assign period_o       = period_q;
    assign period_valid_o = valid_q;
    assign max_o          = max_q;
    assign min_o          = min_q;
    assign timeout_o      = timeout_q;

`ifdef WAVE_PERIOD_AVG_EN
    localparam int unsigned SUM_WIDTH  = CNT_WIDTH + 2;
    localparam int unsigned HCNT_WIDTH = $clog2(AVG_DEPTH + 1);
    localparam int unsigned AVG_SHIFT  = $clog2(AVG_DEPTH);

    logic [CNT_WIDTH-1:0]  hist_q [AVG_DEPTH];
    logic [CNT_WIDTH-1:0]  hist_d [AVG_DEPTH];
    logic [SUM_WIDTH-1:0]  sum_q, sum_d;
    logic [HCNT_WIDTH-1:0] hcnt_q, hcnt_d;
    logic [CNT_WIDTH-1:0]  avg_q, avg_d;

    // Sliding window of the last AVG_DEPTH periods; the oldest slot is zero until filled.
    always_comb begin
        hist_d = hist_q;
        sum_d  = sum_q;
        hcnt_d = hcnt_q;
        avg_d  = avg_q;
        if (rearm_c) begin
            for (int i = 0; i < int'(AVG_DEPTH); i++) hist_d[i] = '0;
            sum_d  = '0;
            hcnt_d = '0;
            avg_d  = '0;
        end else if (valid_d) begin
            sum_d = sum_q + SUM_WIDTH'(period_d) - SUM_WIDTH'(hist_q[AVG_DEPTH-1]);
            for (int i = int'(AVG_DEPTH) - 1; i > 0; i--) hist_d[i] = hist_q[i-1];
            hist_d[0] = period_d;
            if (hcnt_q != HCNT_WIDTH'(AVG_DEPTH)) hcnt_d = hcnt_q + HCNT_WIDTH'(1);
            avg_d = (hcnt_d == HCNT_WIDTH'(AVG_DEPTH)) ? CNT_WIDTH'(sum_d >> AVG_SHIFT) : '0;
        end
    end

    // Averaging registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(AVG_DEPTH); i++) hist_q[i] <= '0;
            sum_q  <= '0;
            hcnt_q <= '0;
            avg_q  <= '0;
        end else begin
            hist_q <= hist_d;
            sum_q  <= sum_d;
            hcnt_q <= hcnt_d;
            avg_q  <= avg_d;
        end
    end

    assign avg_period_o = avg_q;
`endif

endmodule

// File: tb/tb_wave_period_meter.sv
// Self-checking bench for wave_period_meter against a behavioural period model.
module tb_wave_period_meter;
    import waveform_gen_pkg::*;

    localparam int CMAX   = 65535;
    localparam int SETTLE = 1;

    logic clk = 1'b0;
    logic rst_n;
    logic signed [LUT_WIDTH-1:0] wave, wave4;
    wave_sel_t sel, sel4;
    logic halt, halt4;

    logic [15:0] period_o;
    logic        period_valid_o;
    logic signed [LUT_WIDTH-1:0] max_o, min_o;
    logic        timeout_o;
    logic [3:0]  p4;
    logic        v4;
    logic signed [LUT_WIDTH-1:0] mx4, mn4;
    logic        to4;
`ifdef WAVE_PERIOD_AVG_EN
    logic [15:0] avg_period_o;
    logic [3:0]  avg4;
`endif

    wave_period_meter #(.CNT_WIDTH(16), .SETTLE_PERIODS(SETTLE)) u_dut (
        .clk(clk), .rst_n(rst_n), .wave_i(wave), .wave_sel_i(sel), .halt_i(halt),
        .period_o(period_o), .period_valid_o(period_valid_o), .max_o(max_o),
        .min_o(min_o), .timeout_o(timeout_o)
`ifdef WAVE_PERIOD_AVG_EN
        , .avg_period_o(avg_period_o)
`endif
    );

    wave_period_meter #(.CNT_WIDTH(4), .SETTLE_PERIODS(SETTLE)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .wave_i(wave4), .wave_sel_i(sel4), .halt_i(halt4),
        .period_o(p4), .period_valid_o(v4), .max_o(mx4),
        .min_o(mn4), .timeout_o(to4)
`ifdef WAVE_PERIOD_AVG_EN
        , .avg_period_o(avg4)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Behavioural model state: dir is the sign of the last non-zero slope (0 = unknown).
    int m_prev, m_dir, m_cnt, m_settle, m_max, m_min;
    bit m_armed, m_halt;
    wave_sel_t m_sel;
    int m_hist[$];
    int e_period, e_max, e_min, e_avg;
    bit e_valid, e_timeout;

    task automatic model_reset();
        m_prev = 0; m_dir = 0; m_cnt = 0; m_settle = SETTLE; m_max = 0; m_min = 0;
        m_armed = 0; m_halt = 0; m_sel = WAVE_SINE; m_hist.delete();
        e_period = 0; e_max = 0; e_min = 0; e_avg = 0; e_valid = 0; e_timeout = 0;
    endtask

    task automatic model_step(input int w, input wave_sel_t s, input bit h);
        bit rearm;
        bit peak;
        int sum;
        rearm   = (s != m_sel) || (h && !m_halt);
        e_valid = 0;
        if (!h) begin
            peak = (m_dir == 1) && (w < m_prev) && !rearm;
            if (w > m_prev) m_dir = 1;
            else if (w < m_prev) m_dir = -1;
            if (peak) begin
                if (!m_armed) m_armed = 1;
                else if (m_settle > 0) m_settle--;
                else begin
                    e_period  = m_cnt + 1;
                    e_max     = (w > m_max) ? w : m_max;
                    e_min     = (w < m_min) ? w : m_min;
                    e_valid   = 1;
                    e_timeout = 0;
                    m_hist.push_back(e_period);
                    if (m_hist.size() > 4) void'(m_hist.pop_front());
                    sum = 0;
                    foreach (m_hist[i]) sum += m_hist[i];
                    e_avg = (m_hist.size() == 4) ? sum / 4 : 0;
                end
                m_cnt = 0; m_max = w; m_min = w;
            end else begin
                if (m_cnt < CMAX) m_cnt++;
                if (w > m_max) m_max = w;
                if (w < m_min) m_min = w;
                if (m_cnt == CMAX) begin
                    e_timeout = 1; m_armed = 0; m_settle = SETTLE;
                end
            end
            m_prev = w;
        end
        if (rearm) begin
            m_armed = 0; m_settle = SETTLE; m_dir = 0; m_hist.delete(); e_avg = 0;
        end
        m_sel  = s;
        m_halt = h;
    endtask

    function automatic logic [63:0] act_vec();
        logic [15:0] a;
        a = '0;
`ifdef WAVE_PERIOD_AVG_EN
        a = avg_period_o;
`endif
        return {a, period_o, period_valid_o, max_o, min_o, timeout_o, 14'd0};
    endfunction

    function automatic logic [63:0] exp_vec();
        logic [15:0] a;
        a = '0;
`ifdef WAVE_PERIOD_AVG_EN
        a = 16'(e_avg);
`endif
        return {a, 16'(e_period), e_valid, 8'(e_max), 8'(e_min), e_timeout, 14'd0};
    endfunction

    function automatic int tri14(input int t);
        int k;
        k = t % 14;
        return (k <= 7) ? k : 14 - k;
    endfunction

    // 0..7, 7, 7, 6..1: peak detected at index 10 of 16.
    function automatic int tri16p(input int t);
        int k;
        k = t % 16;
        if (k <= 7) return k;
        if (k <= 9) return 7;
        return 16 - k;
    endfunction

    // Drive one cycle of main-DUT inputs, advance the model at the edge, settle #1.
    task automatic tick(input int w, input wave_sel_t s, input bit h);
        wave = LUT_WIDTH'(w);
        sel  = s;
        halt = h;
        @(posedge clk);
        model_step(w, s, h);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wave = '0; sel = WAVE_SINE; halt = 1'b0;
        wave4 = '0; sel4 = WAVE_SINE; halt4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (act_vec() !== 64'd0) begin
            n_fail++; $display("FAIL reset_main act=%h exp=%h", act_vec(), 64'd0);
        end
        n_checks++;
        if ({p4, v4, mx4, mn4, to4} !== 22'd0) begin
            n_fail++; $display("FAIL reset_cnt4 act=%h exp=0", {p4, v4, mx4, mn4, to4});
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_triangle();
        int first, npulse;
        first = -1; npulse = 0;
        for (int t = 0; t < 84; t++) begin
            tick(tri14(t), WAVE_SINE, 1'b0);
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL tri_model cyc=%0d act=%h exp=%h", cyc, act_vec(), exp_vec());
            end
            if (period_valid_o) begin
                if (first < 0) first = t;
                npulse++;
                n_checks++;
                if ({period_o, max_o, min_o} !== {16'd14, 8'sd7, 8'sd0}) begin
                    n_fail++; $display("FAIL tri_pulse p=%0d max=%0d min=%0d exp 14/7/0", period_o, max_o, min_o);
                end
            end
        end
        n_checks++;
        if (first != 36) begin
            n_fail++; $display("FAIL tri_first_pulse act=%0d exp=36", first);
        end
        n_checks++;
        if (npulse != 4) begin
            n_fail++; $display("FAIL tri_pulse_count act=%0d exp=4", npulse);
        end
    endtask

    task automatic test_sawtooth();
        int ts, first_after;
        wave_sel_t s;
        ts = -1; first_after = -1;
        for (int t = 0; t < 150; t++) begin
            if (ts < 0 && t >= 80 && (t % 16) == 5) ts = t;
            s = (ts >= 0) ? WAVE_SQUARE : WAVE_SAW;
            tick(t % 16, s, 1'b0);
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL saw_model cyc=%0d act=%h exp=%h", cyc, act_vec(), exp_vec());
            end
            if (period_valid_o) begin
                if (ts >= 0 && first_after < 0) first_after = t - ts;
                n_checks++;
                if ({period_o, max_o, min_o} !== {16'd16, 8'sd15, 8'sd0}) begin
                    n_fail++; $display("FAIL saw_pulse p=%0d max=%0d min=%0d exp 16/15/0", period_o, max_o, min_o);
                end
            end
        end
        n_checks++;
        if (first_after != 43) begin
            n_fail++; $display("FAIL saw_resettle act=%0d exp=43", first_after);
        end
    endtask

    task automatic test_plateau();
        int npulse;
        npulse = 0;
        for (int t = 0; t < 252; t++) begin
            tick(tri14(t / 3), WAVE_TRIANGLE, 1'b0);
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL plat_model cyc=%0d act=%h exp=%h", cyc, act_vec(), exp_vec());
            end
            if (period_valid_o) begin
                npulse++;
                n_checks++;
                if ({period_o, max_o, min_o} !== {16'd42, 8'sd7, 8'sd0}) begin
                    n_fail++; $display("FAIL plat_pulse p=%0d max=%0d min=%0d exp 42/7/0", period_o, max_o, min_o);
                end
            end
        end
        n_checks++;
        if (npulse != 4) begin
            n_fail++; $display("FAIL plat_pulse_count act=%0d exp=4", npulse);
        end
    endtask

    task automatic test_halt();
        int th, first;
        th = 56 + int'($urandom_range(0, 12));
        first = -1;
        for (int t = 0; t < th; t++) begin
            tick(tri14(t), WAVE_SINE, 1'b0);
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL halt_pre cyc=%0d act=%h exp=%h", cyc, act_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 20; i++) begin
            tick(tri14(th - 1), WAVE_SINE, 1'b1);
            n_checks++;
            if ({period_valid_o, period_o} !== {1'b0, 16'd14}) begin
                n_fail++; $display("FAIL halt_frozen v=%0d p=%0d exp v=0 p=14", period_valid_o, period_o);
            end
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL halt_model cyc=%0d act=%h exp=%h", cyc, act_vec(), exp_vec());
            end
        end
        for (int k = 0; k < 50; k++) begin
            tick(tri14(th + k), WAVE_SINE, 1'b0);
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL halt_post cyc=%0d act=%h exp=%h", cyc, act_vec(), exp_vec());
            end
            if (period_valid_o && first < 0) begin
                first = k;
                n_checks++;
                if (period_o !== 16'd14) begin
                    n_fail++; $display("FAIL halt_period act=%0d exp=14", period_o);
                end
            end
        end
        n_checks++;
        if (first < 29 || first > 42) begin
            n_fail++; $display("FAIL halt_resettle act=%0d exp=29..42", first);
        end
    endtask

    task automatic test_random();
        int v, d, amp, hold, hc, hleft;
        bit hon;
        wave_sel_t rs;
        v = 0; d = 1; amp = 6; hold = 1; hc = 0; hleft = 0; hon = 0; rs = WAVE_SINE;
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 99) == 0) rs = wave_sel_t'($urandom_range(0, 3));
            if (!hon && i < 880 && $urandom_range(0, 149) == 0) begin
                hon = 1; hleft = int'($urandom_range(1, 8));
            end
            if (hon) begin
                tick(v, rs, 1'b1);
                hleft--;
                if (hleft == 0) hon = 0;
            end else begin
                tick(v, rs, 1'b0);
                hc++;
                if (hc >= hold) begin
                    hc = 0;
                    v += d;
                    if (v >= amp) begin
                        d = -1; amp = int'($urandom_range(2, 40)); hold = int'($urandom_range(1, 3));
                    end else if (v <= -amp) begin
                        d = 1; amp = int'($urandom_range(2, 40)); hold = int'($urandom_range(1, 3));
                    end
                end
            end
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL rand_model cyc=%0d act=%h exp=%h", cyc, act_vec(), exp_vec());
            end
        end
    endtask

`ifdef WAVE_PERIOD_AVG_EN
    task automatic test_avg();
        int np;
        int exp_p[4];
        int exp_a[4];
        exp_p = '{14, 14, 16, 16};
        exp_a = '{0, 0, 0, 15};
        np = 0;
        for (int t = 0; t < 4 * 14 + 3 * 16; t++) begin
            tick((t < 56) ? tri14(t) : tri16p(t - 56), WAVE_SAW, 1'b0);
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL avg_model cyc=%0d act=%h exp=%h", cyc, act_vec(), exp_vec());
            end
            if (period_valid_o && np < 4) begin
                n_checks++;
                if ({period_o, avg_period_o} !== {16'(exp_p[np]), 16'(exp_a[np])}) begin
                    n_fail++; $display("FAIL avg_pulse%0d p=%0d avg=%0d exp p=%0d avg=%0d",
                                       np, period_o, avg_period_o, exp_p[np], exp_a[np]);
                end
                np++;
            end
        end
        n_checks++;
        if (np != 4) begin
            n_fail++; $display("FAIL avg_pulse_count act=%0d exp=4", np);
        end
    endtask
`endif

    task automatic test_reset_mid();
        for (int t = 0; t < 45; t++) begin
            tick(tri14(t), WAVE_TRIANGLE, 1'b0);
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL rstmid_pre cyc=%0d act=%h exp=%h", cyc, act_vec(), exp_vec());
            end
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (act_vec() !== 64'd0) begin
            n_fail++; $display("FAIL rstmid_async act=%h exp=0", act_vec());
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_timeout();
        int first;
        first = -1;
        for (int t = 0; t < 31; t++) begin
            wave4 = LUT_WIDTH'((t <= 7) ? t : ((t == 8) ? 6 : 5));
            tick(0, WAVE_SINE, 1'b0);
            if (t == 22) begin
                n_checks++;
                if (to4 !== 1'b0) begin
                    n_fail++; $display("FAIL timeout_early act=%0d exp=0", to4);
                end
            end
            if (t == 23) begin
                n_checks++;
                if (to4 !== 1'b1) begin
                    n_fail++; $display("FAIL timeout_set act=%0d exp=1", to4);
                end
            end
        end
        for (int k = 0; k < 50; k++) begin
            wave4 = LUT_WIDTH'(tri14(k));
            tick(0, WAVE_SINE, 1'b0);
            if (v4 && first < 0) begin
                first = k;
                n_checks++;
                if ({to4, p4, mx4, mn4} !== {1'b0, 4'd14, 8'sd7, 8'sd0}) begin
                    n_fail++; $display("FAIL timeout_clear to=%0d p=%0d max=%0d min=%0d exp 0/14/7/0",
                                       to4, p4, mx4, mn4);
                end
            end else if (first < 0) begin
                n_checks++;
                if (to4 !== 1'b1) begin
                    n_fail++; $display("FAIL timeout_sticky k=%0d act=%0d exp=1", k, to4);
                end
            end
        end
        n_checks++;
        if (first != 36) begin
            n_fail++; $display("FAIL timeout_first_pulse act=%0d exp=36", first);
        end
    endtask

    initial begin
        test_reset();
        test_triangle();
        test_sawtooth();
        test_plateau();
        test_halt();
        test_random();
`ifdef WAVE_PERIOD_AVG_EN
        test_avg();
`endif
        test_reset_mid();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
